// File: rtl/stb_generator_pkg.sv
// Shared constants for the periodic strobe generator and its decade stages.
package stb_generator_pkg;

  // Each decade stage is a 4-bit counter cycling 0..9
  localparam int              DEC_W   = 4;
  localparam logic [DEC_W-1:0] DEC_MAX = 4'd9;

  // Default clocking: 10 MHz system clock, 1 kHz base strobe
  localparam int CLK_HZ_DEFAULT  = 10000000;
  localparam int BASE_HZ_DEFAULT = 1000;

endpackage

// File: rtl/decade_stage.sv
// One decade counter of the strobe cascade: advances 0..9 on tick_in and
// reports a combinational carry when a tick arrives while it sits at 9.
module decade_stage
  import stb_generator_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick_in,
  output logic             carry_out,
  output logic [DEC_W-1:0] cnt
);

  logic [DEC_W-1:0] cnt_q;
  logic [DEC_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance on a tick and wrap 9 -> 0
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick_in) begin
      cnt_d = (cnt_q == DEC_MAX) ? '0 : cnt_q + DEC_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_out = tick_in && (cnt_q == DEC_MAX);
  assign cnt       = cnt_q;

endmodule

// File: rtl/stb_generator.sv
// Periodic strobe generator: a binary prescaler produces the base tick, and
// three cascaded decade stages derive the 10x, 100x and 1000x strobes.
// Optional macro STB_GENERATOR_RESYNC_EN adds sync_in, which clears the
// prescaler and all decades to phase-align the strobes to an external event.
module stb_generator
  import stb_generator_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int BASE_HZ = BASE_HZ_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
`ifdef STB_GENERATOR_RESYNC_EN
  input  logic sync_in,
`endif
  output logic stb_1ms,
  output logic stb_10ms,
  output logic stb_100ms,
  output logic stb_1s
);

  localparam int DIV   = CLK_HZ / BASE_HZ;
  localparam int PRE_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  // Reject clock ratios that cannot give an exact, multi-cycle base period
  generate
    if (DIV < 2 || (CLK_HZ % BASE_HZ) != 0) begin : g_bad_cfg
      $error("stb_generator: CLK_HZ must be a multiple of BASE_HZ with DIV >= 2");
    end
  endgenerate

  logic resync;
`ifdef STB_GENERATOR_RESYNC_EN
  assign resync = sync_in;
`else
  assign resync = 1'b0;
`endif

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             base_tick;
  logic             carry0;
  logic             carry1;
  logic             carry2;
  logic [DEC_W-1:0] d0_cnt;
  logic [DEC_W-1:0] d1_cnt;
  logic [DEC_W-1:0] d2_cnt;
  logic [3:0]       stb_q;
  logic [3:0]       stb_d;

  // Base tick only on an enabled cycle at the top of the prescaler; a resync
  // suppresses it so nothing downstream advances on that edge
  always_comb begin
    base_tick = en && !resync && (pre_q == PRE_MAX);
    pre_d     = pre_q;
    if (resync) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = base_tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  decade_stage u_d0 (
    .clk       (clk),
    .reset     (reset),
    .clr       (resync),
    .tick_in   (base_tick),
    .carry_out (carry0),
    .cnt       (d0_cnt)
  );

  decade_stage u_d1 (
    .clk       (clk),
    .reset     (reset),
    .clr       (resync),
    .tick_in   (carry0),
    .carry_out (carry1),
    .cnt       (d1_cnt)
  );

  decade_stage u_d2 (
    .clk       (clk),
    .reset     (reset),
    .clr       (resync),
    .tick_in   (carry1),
    .carry_out (carry2),
    .cnt       (d2_cnt)
  );

  // Strobe conditions; each slower strobe implies all the faster ones
  always_comb begin
    stb_d    = '0;
    stb_d[0] = base_tick;
    stb_d[1] = base_tick && (d0_cnt == DEC_MAX);
    stb_d[2] = carry0 && (d1_cnt == DEC_MAX);
    stb_d[3] = carry1 && (d2_cnt == DEC_MAX) && carry2;
  end

  // Register the strobes so each output is a clean one-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      stb_q <= '0;
    end else begin
      stb_q <= stb_d;
    end
  end

  assign stb_1ms   = stb_q[0];
  assign stb_10ms  = stb_q[1];
  assign stb_100ms = stb_q[2];
  assign stb_1s    = stb_q[3];

endmodule
